oem_frame_serializer: RTL and testbench



---
 rtl/oem_pkg.sv | 24 ++
 rtl/oem_pingpong_buf.sv | 49 ++++
 rtl/oem_frame_serializer.sv | 101 ++++++++++
 tb/tb_oem_frame_serializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/oem_pkg.sv
// Shared definitions for the odd-even-merge frame serializer.
// Holds default sizing, the slot occupancy state encoding and a lane-extract helper.
package oem_pkg;

    localparam int unsigned OEM_W     = 6;
    localparam int unsigned OEM_N     = 16;
    localparam int unsigned OEM_IDX_W = $clog2(OEM_N);

    // Number of frames currently parked in the ping-pong buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_state_t;

    // Pull one element out of a default-sized packed frame.
    function automatic logic [OEM_W-1:0] lane_extract(
        input logic [OEM_N*OEM_W-1:0] frame,
        input logic [OEM_IDX_W-1:0]   lane
    );
        return frame[lane*OEM_W +: OEM_W];
    endfunction

endpackage

// File: rtl/oem_pingpong_buf.sv
// Two-slot frame store with independent write and read pointers.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointers only)
//   wr_en      : latch wr_data into slot[wr_ptr] and toggle wr_ptr
//   wr_data    : full frame to store
//   rd_adv     : toggle rd_ptr (current frame fully drained)
//   rd_data    : contents of slot[rd_ptr]
module oem_pingpong_buf
    import oem_pkg::*;
#(
    parameter int unsigned FW = OEM_N * OEM_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [FW-1:0] wr_data,
    input  logic          rd_adv,
    output logic [FW-1:0] rd_data
);

    logic [FW-1:0] slot [2];
    logic          wr_ptr;
    logic          rd_ptr;

    // Slot payloads carry no reset; occupancy gating makes their value irrelevant.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            slot[wr_ptr] <= wr_data;
        end
    end

    // Pointer toggles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= ~wr_ptr;
            end
            if (rd_adv) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign rd_data = slot[rd_ptr];

endmodule

// File: rtl/oem_frame_serializer.sv
// Drains sorted N-lane frames into a one-element-per-clock stream.
// A two-slot ping-pong buffer lets the next frame load while the current one drains.
// Ports:
//   clk, rst_n           : clock, async active-low reset
//   frm_valid/frm_ready  : frame-side handshake, frm_data lane k at [k*W +: W]
//   el_valid/el_ready    : element-side handshake, el_data current element
//   el_first/el_last     : element is position 0 / N-1 of its frame
//   el_idx               : position of el_data within its frame
//   frm_cnt              : fully emitted frames, wraps at 256
//   busy                 : at least one slot occupied
module oem_frame_serializer
    import oem_pkg::*;
#(
    parameter int unsigned W       = OEM_W,
    parameter int unsigned N       = OEM_N,
    parameter bit          DESCEND = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frm_valid,
    output logic                 frm_ready,
    input  logic [N*W-1:0]       frm_data,
    output logic                 el_valid,
    input  logic                 el_ready,
    output logic [W-1:0]         el_data,
    output logic                 el_first,
    output logic                 el_last,
    output logic [$clog2(N)-1:0] el_idx,
    output logic [7:0]           frm_cnt,
    output logic                 busy
);

    localparam int unsigned IDX_W = $clog2(N);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    occ_state_t       state;
    logic [IDX_W-1:0] idx;
    logic [7:0]       cnt;
    logic [N*W-1:0]   rd_frame;
    logic [IDX_W-1:0] lane;
    logic             accept;
    logic             xfer;
    logic             release_slot;

    // Handshake status is decoded purely from the state register.
    assign frm_ready    = (state != FULL);
    assign el_valid     = (state != EMPTY);
    assign busy         = (state != EMPTY);
    assign accept       = frm_valid & frm_ready;
    assign xfer         = el_valid & el_ready;
    assign release_slot = xfer & (idx == IDX_MAX);

    oem_pingpong_buf #(
        .FW (N * W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept),
        .wr_data (frm_data),
        .rd_adv  (release_slot),
        .rd_data (rd_frame)
    );

    // Occupancy, element index and frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) state <= ONE;
                ONE: begin
                    if (accept && !release_slot)      state <= FULL;
                    else if (!accept && release_slot) state <= EMPTY;
                end
                FULL:  if (release_slot) state <= ONE;
                default: state <= EMPTY;
            endcase

            if (xfer) begin
                if (idx == IDX_MAX) begin
                    idx <= '0;
                    cnt <= cnt + 8'd1;
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

    // Descending order reads the frame from its top lane down.
    assign lane = DESCEND ? (IDX_MAX - idx) : idx;

    assign el_data  = el_valid ? rd_frame[lane*W +: W] : '0;
    assign el_idx   = idx;
    assign el_first = el_valid & (idx == '0);
    assign el_last  = el_valid & (idx == IDX_MAX);
    assign frm_cnt  = cnt;

endmodule

// File: tb/tb_oem_frame_serializer.sv
// Directed bench for oem_frame_serializer; a second instance with DESCEND=1 shares the inputs.
module tb_oem_frame_serializer;

    localparam int unsigned W = 6;
    localparam int unsigned N = 16;

    logic           clk;
    logic           rst_n;
    logic           frm_valid;
    logic [N*W-1:0] frm_data;
    logic           el_ready;

    logic           frm_ready,   frm_ready_d;
    logic           el_valid,    el_valid_d;
    logic [W-1:0]   el_data,     el_data_d;
    logic           el_first,    el_first_d;
    logic           el_last,     el_last_d;
    logic [3:0]     el_idx,      el_idx_d;
    logic [7:0]     frm_cnt,     frm_cnt_d;
    logic           busy,        busy_d;

    int checks = 0;
    int errors = 0;

    oem_frame_serializer #(.W(W), .N(N), .DESCEND(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .frm_valid(frm_valid), .frm_ready(frm_ready), .frm_data(frm_data),
        .el_valid(el_valid), .el_ready(el_ready), .el_data(el_data),
        .el_first(el_first), .el_last(el_last), .el_idx(el_idx),
        .frm_cnt(frm_cnt), .busy(busy)
    );

    oem_frame_serializer #(.W(W), .N(N), .DESCEND(1'b1)) dut_d (
        .clk(clk), .rst_n(rst_n),
        .frm_valid(frm_valid), .frm_ready(frm_ready_d), .frm_data(frm_data),
        .el_valid(el_valid_d), .el_ready(el_ready), .el_data(el_data_d),
        .el_first(el_first_d), .el_last(el_last_d), .el_idx(el_idx_d),
        .frm_cnt(frm_cnt_d), .busy(busy_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame builders: lane k gets base + step*k (6-bit wrap not needed for these values).
    function automatic logic [N*W-1:0] ramp(input int base, input int step);
        logic [N*W-1:0] f;
        for (int k = 0; k < N; k++) f[k*W +: W] = W'(base + step * k);
        return f;
    endfunction

    initial begin
        int e;
        rst_n     = 1'b0;
        frm_valid = 1'b0;
        frm_data  = '0;
        el_ready  = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_el_valid", el_valid, 0);
        check("rst_el_data", el_data, 0);
        check("rst_el_first", el_first, 0);
        check("rst_el_last", el_last, 0);
        check("rst_el_idx", el_idx, 0);
        check("rst_frm_cnt", frm_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_frm_ready", frm_ready, 1);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame 1,3,...,31; descending instance emits 31..1
        frm_valid = 1'b1;
        frm_data  = ramp(1, 2);
        el_ready  = 1'b1;
        @(negedge clk);
        frm_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("s1_valid", el_valid, 1);
            check("s1_data", el_data, 2 * k + 1);
            check("s1_idx", el_idx, k);
            check("s1_first", el_first, (k == 0));
            check("s1_last", el_last, (k == 15));
            check("s1_desc_data", el_data_d, 31 - 2 * k);
            check("s1_desc_idx", el_idx_d, k);
            @(negedge clk);
        end
        check("s1_idle_valid", el_valid, 0);
        check("s1_idle_data", el_data, 0);
        check("s1_busy", busy, 0);
        check("s1_frm_cnt", frm_cnt, 1);

        // Back-to-back frames A (all 5) and B (all 60)
        frm_valid = 1'b1;
        frm_data  = ramp(5, 0);
        @(negedge clk);
        frm_data  = ramp(60, 0);
        for (int i = 0; i < 32; i++) begin
            check("b2b_valid", el_valid, 1);
            check("b2b_data", el_data, (i < 16) ? 5 : 60);
            check("b2b_idx", el_idx, i % 16);
            if (i == 1) begin
                check("b2b_full", frm_ready, 0);
                frm_valid = 1'b0;
            end
            if (i == 15) check("b2b_ready_at_last", frm_ready, 0);
            if (i == 16) check("b2b_ready_after_last", frm_ready, 1);
            @(negedge clk);
        end
        check("b2b_idle", el_valid, 0);
        check("b2b_frm_cnt", frm_cnt, 3);

        // Backpressure on 63-k with el_ready pattern 1,0,0,1,0,0,...
        el_ready  = 1'b0;
        frm_valid = 1'b1;
        frm_data  = ramp(63, -1);
        @(negedge clk);
        frm_valid = 1'b0;
        e = 0;
        for (int c = 0; c < 80 && e < 16; c++) begin
            check("bp_valid", el_valid, 1);
            check("bp_data", el_data, 63 - e);
            check("bp_idx", el_idx, e);
            el_ready = (c % 3 == 0);
            @(negedge clk);
            if (el_ready) e++;
        end
        el_ready = 1'b0;
        check("bp_count", e, 16);
        check("bp_idle", el_valid, 0);
        check("bp_frm_cnt", frm_cnt, 4);

        // Full buffer: C = 20+k, D = 40+k, third frame (all 7) must be ignored
        frm_valid = 1'b1;
        frm_data  = ramp(20, 1);
        @(negedge clk);
        frm_data  = ramp(40, 1);
        @(negedge clk);
        frm_data  = ramp(7, 0);
        check("full_ready", frm_ready, 0);
        for (int p = 0; p < 16; p++) begin
            check("full_ready_hold", frm_ready, 0);
            check("full_data", el_data, 20 + p);
            check("full_idx", el_idx, p);
            el_ready = 1'b1;
            if (p == 15) frm_valid = 1'b0;
            @(negedge clk);
            el_ready = 1'b0;
            if (p < 15) begin
                check("full_stall_data", el_data, 21 + p);
                @(negedge clk);
            end
        end
        check("full_ready_rise", frm_ready, 1);
        check("full_next_data", el_data, 40);
        check("full_next_first", el_first, 1);
        el_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("full_d_data", el_data, 40 + k);
            @(negedge clk);
        end
        el_ready = 1'b0;
        check("full_idle", busy, 0);
        check("full_frm_cnt", frm_cnt, 6);

        // Reset in the middle of a frame
        frm_valid = 1'b1;
        frm_data  = ramp(1, 2);
        el_ready  = 1'b1;
        @(negedge clk);
        frm_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid_idx", el_idx, 7);
        check("mid_data", el_data, 15);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", el_valid, 0);
        check("mid_rst_data", el_data, 0);
        check("mid_rst_cnt", frm_cnt, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", frm_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        frm_valid = 1'b1;
        frm_data  = ramp(63, -1);
        @(negedge clk);
        frm_valid = 1'b0;
        check("post_rst_idx", el_idx, 0);
        check("post_rst_first", el_first, 1);
        check("post_rst_data", el_data, 63);
        repeat (16) @(negedge clk);
        check("post_rst_cnt", frm_cnt, 1);
        check("post_rst_busy", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
